// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between MEM-stage load/store logic and a
// byte-addressed data memory that only supports sb and full-word writes.
// Stores enqueue in one cycle and drain in order whenever the memory port is
// free. Loads are forwarded from a same-word sw or stalled on partial overlap.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   st_valid/op/addr/data   store request from MEM stage
//   st_ready                buffer has room for a store this cycle
//   st_err                  one-cycle pulse: previous store was rejected
//   ld_valid/addr           load request from MEM stage
//   ld_hit/ld_data          forwarded word for the load
//   ld_stall                hold the load; conflicting entries still pending
//   dm_we/op/addr/din       data memory write port (driven from head entry)
//   empty                   no entries held
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic [5:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        st_err,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic [31:0] ld_data,
  output logic        ld_stall,
  output logic        dm_we,
  output logic [5:0]  dm_op,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  output logic        empty
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [5:0]    OP_SB    = 6'b101000;
  localparam logic [5:0]    OP_SH    = 6'b101001;
  localparam logic [5:0]    OP_SW    = 6'b101011;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic          r_valid [DEPTH];
  logic [5:0]    r_op    [DEPTH];
  logic [31:0]   r_addr  [DEPTH];
  logic [31:0]   r_data  [DEPTH];
  logic          r_half  [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic          r_st_err;

  logic          w_bad;
  logic          w_push;
  logic          w_pop;
  logic          w_sh_first;
  logic          w_match_any;
  logic          w_young_sw;
  logic [31:0]   w_young_data;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_unused_ld;

  // Word-granular load compare ignores the byte offset.
  assign w_unused_ld = ld_addr[1:0];

  assign st_ready = (r_count < CNT_FULL);
  assign empty    = (r_count == (AW+1)'(0));
  assign st_err   = r_st_err;
  assign w_push   = st_valid && st_ready && !w_bad;
  assign dm_we    = !empty && (!ld_valid || ld_stall);
  // The first half of an sh only flips its half flag; the entry stays.
  assign w_pop    = dm_we && !w_sh_first;

  // Illegal opcode or misaligned sh/sw.
  always_comb begin
    w_bad = 1'b0;
    case (st_op)
      OP_SB:   w_bad = 1'b0;
      OP_SH:   w_bad = st_addr[0];
      OP_SW:   w_bad = |st_addr[1:0];
      default: w_bad = 1'b1;
    endcase
  end

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    w_match_any  = 1'b0;
    w_young_sw   = 1'b0;
    w_young_data = 32'd0;
    w_idx        = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + AW'(k);
      if (((AW+1)'(k) < r_count) && r_valid[w_idx] &&
          (r_addr[w_idx][31:2] == ld_addr[31:2])) begin
        w_match_any  = 1'b1;
        w_young_sw   = (r_op[w_idx] == OP_SW);
        w_young_data = r_data[w_idx];
      end else begin
        w_match_any  = w_match_any;
      end
    end
  end

  // Load decision; a same-cycle store always stalls the load.
  always_comb begin
    ld_hit   = 1'b0;
    ld_stall = 1'b0;
    ld_data  = 32'd0;
    if (!ld_valid) begin
      ld_hit   = 1'b0;
    end else if (st_valid) begin
      ld_stall = 1'b1;
    end else if (w_match_any && w_young_sw) begin
      ld_hit   = 1'b1;
      ld_data  = w_young_data;
    end else if (w_match_any) begin
      ld_stall = 1'b1;
    end else begin
      ld_hit   = 1'b0;
    end
  end

  // Memory write fields from the head entry; sh becomes two byte writes.
  always_comb begin
    dm_op      = 6'd0;
    dm_addr    = r_addr[r_head];
    dm_din     = r_data[r_head];
    w_sh_first = 1'b0;
    case (r_op[r_head])
      OP_SW: dm_op = OP_SW;
      OP_SB: begin
        dm_op  = OP_SB;
        dm_din = {24'd0, r_data[r_head][7:0]};
      end
      OP_SH: begin
        dm_op = OP_SB;
        if (r_half[r_head]) begin
          dm_addr = r_addr[r_head] + 32'd1;
          dm_din  = {24'd0, r_data[r_head][15:8]};
        end else begin
          dm_din     = {24'd0, r_data[r_head][7:0]};
          w_sh_first = 1'b1;
        end
      end
      default: dm_op = 6'd0;
    endcase
  end

  // FIFO state, entry storage and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_op[i]    <= 6'd0;
        r_addr[i]  <= 32'd0;
        r_data[i]  <= 32'd0;
        r_half[i]  <= 1'b0;
      end
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_st_err <= 1'b0;
    end else begin
      r_st_err <= st_valid && w_bad;
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_op[r_tail]    <= st_op;
        r_addr[r_tail]  <= st_addr;
        r_data[r_tail]  <= st_data;
        r_half[r_tail]  <= 1'b0;
        r_tail          <= r_tail + AW'(1);
      end
      if (dm_we && w_sh_first) begin
        r_half[r_head] <= 1'b1;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  logic        clk, rst_n;
  logic        st_valid, st_ready, st_err;
  logic [5:0]  st_op;
  logic [31:0] st_addr, st_data;
  logic        ld_valid, ld_hit, ld_stall;
  logic [31:0] ld_addr, ld_data;
  logic        dm_we, empty;
  logic [5:0]  dm_op;
  logic [31:0] dm_addr, dm_din;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] din;
  } wr_t;
  wr_t sb_q[$];

  logic [7:0] mem [4096];

  typedef struct {
    logic        sv;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic        lv;
    logic [31:0] la;
    logic        acc;
    logic        hit;
    logic [31:0] ldd;
    logic        stall;
    logic        we;
    logic        rdy;
  } vec_t;
  vec_t vecs[21];

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .st_err(st_err),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .ld_stall(ld_stall),
    .dm_we(dm_we), .dm_op(dm_op), .dm_addr(dm_addr), .dm_din(dm_din),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    case (op)
      OP_SW: sb_q.push_back('{OP_SW, a, d});
      OP_SB: sb_q.push_back('{OP_SB, a, {24'd0, d[7:0]}});
      OP_SH: begin
        sb_q.push_back('{OP_SB, a, {24'd0, d[7:0]}});
        sb_q.push_back('{OP_SB, a + 32'd1, {24'd0, d[15:8]}});
      end
      default: ;
    endcase
  endtask

  // Memory write scoreboard and byte-addressed memory model (negedge write)
  always @(negedge clk) begin
    if (rst_n && dm_we) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got op %b addr %h din %h expected no write",
                 dm_op, dm_addr, dm_din);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        if (dm_op !== e.op || dm_addr !== e.addr || dm_din !== e.din) begin
          errors++;
          $display("FAIL mem_write: got op %b addr %h din %h expected op %b addr %h din %h",
                   dm_op, dm_addr, dm_din, e.op, e.addr, e.din);
        end
      end
      if (dm_op == OP_SB) begin
        mem[dm_addr[11:0]] = dm_din[7:0];
      end else begin
        for (int b = 0; b < 4; b++) mem[dm_addr[11:0] + 12'(b)] = dm_din[8*b +: 8];
      end
    end
  end

  // Apply one cycle: drive at posedge+1, check combinational outputs at negedge.
  task automatic step(input vec_t v, input string nm);
    st_valid = v.sv; st_op = v.op; st_addr = v.a; st_data = v.d;
    ld_valid = v.lv; ld_addr = v.la;
    if (v.acc) push_exp(v.op, v.a, v.d);
    @(negedge clk);
    chk({nm, " ld_hit"},   {31'd0, ld_hit},   {31'd0, v.hit});
    chk({nm, " ld_stall"}, {31'd0, ld_stall}, {31'd0, v.stall});
    chk({nm, " dm_we"},    {31'd0, dm_we},    {31'd0, v.we});
    chk({nm, " st_ready"}, {31'd0, st_ready}, {31'd0, v.rdy});
    if (v.hit) chk({nm, " ld_data"}, ld_data, v.ldd);
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic sv, input logic [5:0] op, input logic [31:0] a,
                              input logic [31:0] d, input logic lv, input logic [31:0] la,
                              input logic acc, input logic hit, input logic [31:0] ldd,
                              input logic stall, input logic we, input logic rdy);
    vec_t v;
    v.sv = sv; v.op = op; v.a = a; v.d = d; v.lv = lv; v.la = la;
    v.acc = acc; v.hit = hit; v.ldd = ldd; v.stall = stall; v.we = we; v.rdy = rdy;
    return v;
  endfunction

  function automatic vec_t idle(input logic lv, input logic [31:0] la, input logic hit,
                                input logic [31:0] ldd, input logic stall, input logic we);
    return mk(1'b0, 6'd0, 32'd0, 32'd0, lv, la, 1'b0, hit, ldd, stall, we, 1'b1);
  endfunction

  task automatic drain(input string nm);
    int n;
    st_valid = 1'b0; ld_valid = 1'b0;
    n = 0;
    while (!empty && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    chk({nm, " drain_empty"}, {31'd0, empty}, 32'd1);
    chk({nm, " sb_left"}, sb_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] mword(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  initial begin
    vec_t v;
    logic [31:0] d;
    logic [5:0]  bad_op [3];
    logic [31:0] bad_a  [3];
    for (int i = 0; i < 4096; i++) mem[i] = 8'd0;
    rst_n = 1'b0; st_valid = 1'b0; st_op = 6'd0; st_addr = 32'd0; st_data = 32'd0;
    ld_valid = 1'b0; ld_addr = 32'd0;

    // Table: forward, partial-overlap stall, youngest match, fill to full
    vecs[0]  = mk(1, OP_SW, 32'h10, 32'hDEADBEEF, 0, 0, 1, 0, 0, 0, 0, 1);
    vecs[1]  = idle(1, 32'h12, 1, 32'hDEADBEEF, 0, 0);
    vecs[2]  = idle(0, 0, 0, 0, 0, 1);
    vecs[3]  = mk(1, OP_SB, 32'h31, 32'h7F, 0, 0, 1, 0, 0, 0, 0, 1);
    vecs[4]  = idle(1, 32'h30, 0, 0, 1, 1);
    vecs[5]  = idle(1, 32'h30, 0, 0, 0, 0);
    vecs[6]  = mk(1, OP_SH, 32'h50, 32'hBEEF, 0, 0, 1, 0, 0, 0, 0, 1);
    vecs[7]  = mk(1, OP_SW, 32'h40, 32'd1, 1, 32'h40, 1, 0, 0, 1, 1, 1);
    vecs[8]  = mk(1, OP_SW, 32'h40, 32'd2, 1, 32'h40, 1, 0, 0, 1, 1, 1);
    vecs[9]  = idle(1, 32'h40, 1, 32'd2, 0, 0);
    vecs[10] = idle(0, 0, 0, 0, 0, 1);
    vecs[11] = idle(0, 0, 0, 0, 0, 1);
    vecs[12] = idle(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++)
      vecs[13+k] = mk(1, OP_SH, 32'h100 + 32'(4*k), 32'h1100 + 32'(k * 32'h0101), 0, 0,
                      (k < 6), 0, 0, 0, (k != 0), (k < 6));
    vecs[20] = idle(1, 32'h300, 0, 0, 0, 0);

    // Reset state
    #12;
    chk("rst st_ready", {31'd0, st_ready}, 32'd1);
    chk("rst empty",    {31'd0, empty},    32'd1);
    chk("rst dm_we",    {31'd0, dm_we},    32'd0);
    chk("rst dm_op",    {26'd0, dm_op},    32'd0);
    chk("rst dm_addr",  dm_addr,           32'd0);
    chk("rst dm_din",   dm_din,            32'd0);
    chk("rst ld_hit",   {31'd0, ld_hit},   32'd0);
    chk("rst ld_stall", {31'd0, ld_stall}, 32'd0);
    chk("rst st_err",   {31'd0, st_err},   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) step(vecs[i], $sformatf("vec%0d", i));
    drain("table");
    chk("mem 0x10", mword(32'h10), 32'hDEADBEEF);
    chk("mem 0x31", {24'd0, mem[32'h31]}, 32'h7F);
    chk("mem 0x40", mword(32'h40), 32'd2);
    chk("mem 0x114", mword(32'h114), 32'h00001605);

    // Rejected stores: bad opcode, odd sh, misaligned sw
    bad_op[0] = 6'b100011; bad_a[0] = 32'h20;
    bad_op[1] = OP_SH;     bad_a[1] = 32'h21;
    bad_op[2] = OP_SW;     bad_a[2] = 32'h42;
    for (int k = 0; k < 3; k++) begin
      step(mk(1, bad_op[k], bad_a[k], 32'h55, 0, 0, 0, 0, 0, 0, 0, 1), $sformatf("bad%0d", k));
      chk($sformatf("bad%0d st_err", k), {31'd0, st_err}, 32'd1);
      chk($sformatf("bad%0d empty", k), {31'd0, empty}, 32'd1);
    end

    // sh split into two byte writes
    step(mk(1, OP_SH, 32'h22, 32'h0000A55A, 0, 0, 1, 0, 0, 0, 0, 1), "sh22");
    chk("sh22 st_err", {31'd0, st_err}, 32'd0);
    step(idle(0, 0, 0, 0, 0, 1), "sh22_lo");
    step(idle(0, 0, 0, 0, 0, 1), "sh22_hi");
    step(idle(0, 0, 0, 0, 0, 0), "sh22_done");
    chk("mem 0x22", {16'd0, mem[32'h23], mem[32'h22]}, 32'h0000A55A);

    // Pointer wrap: back-to-back sw push/drain
    for (int k = 0; k < 6; k++) begin
      d = $urandom;
      step(mk(1, OP_SW, 32'h200 + 32'(4*k), d, 0, 0, 1, 0, 0, 0, (k != 0), 1),
           $sformatf("wrap%0d", k));
    end
    drain("wrap");

    // Asynchronous reset between the two halves of an sh
    step(mk(1, OP_SH, 32'h60, 32'h1234, 0, 0, 1, 0, 0, 0, 0, 1), "rsh");
    step(idle(0, 0, 0, 0, 0, 1), "rsh_lo");
    rst_n = 1'b0;
    #1;
    chk("rsh dm_we", {31'd0, dm_we}, 32'd0);
    chk("rsh empty", {31'd0, empty}, 32'd1);
    sb_q.delete();
    #2 rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("rsh after empty", {31'd0, empty}, 32'd1);
    chk("rsh mem 0x60", {24'd0, mem[32'h60]}, 32'h34);
    chk("rsh mem 0x61", {24'd0, mem[32'h61]}, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
